// File: rtl/sdram_arb_pkg.sv
// Shared state type, counter width and sizing helper for the sdram port arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   localparam int unsigned CNT_W = 4;

   // Ceiling log2, minimum 0; used to size the winner index.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sdram_arb_picker.sv
// Combinational winner selection: round-robin from a pointer, or fixed priority
// with port 0 highest. Masked requests are never eligible.
module sdram_arb_picker
   import sdram_arb_pkg::*;
#(
   parameter  int unsigned NUM_PORTS = 3,
   parameter  int unsigned RR_EN     = 1,
   localparam int unsigned IDX_W     = clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [NUM_PORTS-1:0] i_mask,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic                 o_valid_c,
   output logic [IDX_W-1:0]     o_idx_c
);

   logic [NUM_PORTS-1:0] w_elig;
   logic [IDX_W-1:0]     w_start;
   logic [31:0]          w_k;
   logic                 w_found;

   assign w_elig    = i_req & ~i_mask;
   assign w_start   = (RR_EN != 0) ? i_ptr : '0;
   assign o_valid_c = |w_elig;

   // Scan ports starting at w_start, wrapping at NUM_PORTS; first eligible wins.
   always_comb begin
      w_k     = '0;
      w_found = 1'b0;
      o_idx_c = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         w_k = 32'(w_start) + i;
         if (w_k >= NUM_PORTS) w_k = w_k - NUM_PORTS;
         if (!w_found && w_elig[w_k[IDX_W-1:0]]) begin
            w_found = 1'b1;
            o_idx_c = w_k[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-port req/ack front end for the single-port sdram controller, one access per cep slot.
// Optional per-port grant and stall counters when SDRAM_ARB_STATS_EN is defined.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter  int unsigned NUM_PORTS  = 3,
   parameter  int unsigned ADDR_W     = 25,
   parameter  int unsigned DATA_W     = 16,
   parameter  int unsigned RD_LATENCY = 8,
   parameter  int unsigned RR_EN      = 1,
   localparam int unsigned DS_W       = DATA_W / 8,
   localparam int unsigned IDX_W      = clog2(NUM_PORTS)
) (
   input  logic                          clk_sys,
   input  logic                          RESET,
   input  logic                          cep,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   input  logic [NUM_PORTS*DS_W-1:0]     ds,
   output logic [NUM_PORTS-1:0]          ack,
   output logic [DATA_W-1:0]             rdata,
   output logic [ADDR_W-1:0]             sdram_addr,
   output logic [DATA_W-1:0]             sdram_din,
   output logic [DS_W-1:0]               sdram_ds,
   output logic                          sdram_we,
   output logic                          sdram_oe,
   input  logic [DATA_W-1:0]             sdram_out,
   output logic                          busy
`ifdef SDRAM_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*16-1:0]       stat_cnt,
   output logic [15:0]                   stall_cnt
`endif
);

   arb_state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]     r_win, w_win_nxt;
   logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
   logic [NUM_PORTS-1:0] r_mask, w_mask_nxt;
   logic [NUM_PORTS-1:0] r_ack, w_ack_nxt;
   logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
   logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
   logic [DATA_W-1:0]    r_din, w_din_nxt;
   logic [DS_W-1:0]      r_ds, w_ds_nxt;
   logic                 r_we, w_we_nxt;
   logic                 r_oe, w_oe_nxt;
   logic                 r_busy, w_busy_nxt;

   logic                 w_pick_valid;
   logic [IDX_W-1:0]     w_pick_idx;
   logic                 w_grant;

   sdram_arb_picker #(
      .NUM_PORTS (NUM_PORTS),
      .RR_EN     (RR_EN)
   ) u_picker (
      .i_req     (req),
      .i_mask    (r_mask),
      .i_ptr     (r_ptr),
      .o_valid_c (w_pick_valid),
      .o_idx_c   (w_pick_idx)
   );

   assign w_grant = (r_state == IDLE) && cep && w_pick_valid;

   // State and all registered outputs.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_win   <= '0;
         r_ptr   <= '0;
         r_mask  <= '0;
         r_ack   <= '0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_din   <= '0;
         r_ds    <= '0;
         r_we    <= 1'b0;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_win   <= w_win_nxt;
         r_ptr   <= w_ptr_nxt;
         r_mask  <= w_mask_nxt;
         r_ack   <= w_ack_nxt;
         r_rdata <= w_rdata_nxt;
         r_addr  <= w_addr_nxt;
         r_din   <= w_din_nxt;
         r_ds    <= w_ds_nxt;
         r_we    <= w_we_nxt;
         r_oe    <= w_oe_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next state and next register values; ack and mask default low so they pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_win_nxt   = r_win;
      w_ptr_nxt   = r_ptr;
      w_mask_nxt  = '0;
      w_ack_nxt   = '0;
      w_rdata_nxt = r_rdata;
      w_addr_nxt  = r_addr;
      w_din_nxt   = r_din;
      w_ds_nxt    = r_ds;
      w_we_nxt    = r_we;
      w_oe_nxt    = r_oe;

      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_state_nxt = WAIT;
               w_win_nxt   = w_pick_idx;
               w_ptr_nxt   = (32'(w_pick_idx) == NUM_PORTS - 1) ? '0
                                                                : w_pick_idx + IDX_W'(1);
               w_addr_nxt  = addr[32'(w_pick_idx) * ADDR_W +: ADDR_W];
               w_din_nxt   = wdata[32'(w_pick_idx) * DATA_W +: DATA_W];
               w_ds_nxt    = ds[32'(w_pick_idx) * DS_W +: DS_W];
               w_we_nxt    = we[w_pick_idx];
               w_oe_nxt    = ~we[w_pick_idx];
               w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt      = DONE;
               w_rdata_nxt      = sdram_out;
               w_ack_nxt[r_win] = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DONE: begin
            w_state_nxt       = IDLE;
            w_we_nxt          = 1'b0;
            w_oe_nxt          = 1'b0;
            w_mask_nxt[r_win] = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   assign ack        = r_ack;
   assign rdata      = r_rdata;
   assign sdram_addr = r_addr;
   assign sdram_din  = r_din;
   assign sdram_ds   = r_ds;
   assign sdram_we   = r_we;
   assign sdram_oe   = r_oe;
   assign busy       = r_busy;

`ifdef SDRAM_ARB_STATS_EN
   logic [NUM_PORTS*16-1:0] r_stat, w_stat_nxt;
   logic [15:0]             r_stall, w_stall_nxt;
   logic [15:0]             w_stat_sel;

   assign w_stat_sel = r_stat[32'(w_pick_idx) * 16 +: 16];

   // Saturating grant counters and lost-slot counter.
   always_comb begin
      w_stat_nxt  = r_stat;
      w_stall_nxt = r_stall;
      if (w_grant && (w_stat_sel != 16'hFFFF)) begin
         w_stat_nxt[32'(w_pick_idx) * 16 +: 16] = w_stat_sel + 16'd1;
      end
      if (cep && (|req) && (r_state != IDLE) && (r_stall != 16'hFFFF)) begin
         w_stall_nxt = r_stall + 16'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         r_stat  <= '0;
         r_stall <= '0;
      end else begin
         r_stat  <= w_stat_nxt;
         r_stall <= w_stall_nxt;
      end
   end

   assign stat_cnt  = r_stat;
   assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a round-robin instance and a fixed-priority instance.
module tb_sdram_port_arbiter;

   localparam int unsigned NP  = 3;
   localparam int unsigned AW  = 25;
   localparam int unsigned DW  = 16;
   localparam int unsigned DSW = 2;

   logic               clk_sys = 1'b0;
   logic               RESET;
   logic               cep;
   logic [NP-1:0]      req, req_fp, we;
   logic [NP*AW-1:0]   addr;
   logic [NP*DW-1:0]   wdata;
   logic [NP*DSW-1:0]  ds;
   logic [DW-1:0]      sdram_out;

   logic [NP-1:0]      ack, ack_fp;
   logic [DW-1:0]      rdata, rdata_fp;
   logic [AW-1:0]      sdram_addr, sdram_addr_fp;
   logic [DW-1:0]      sdram_din, sdram_din_fp;
   logic [DSW-1:0]     sdram_ds, sdram_ds_fp;
   logic               sdram_we, sdram_we_fp;
   logic               sdram_oe, sdram_oe_fp;
   logic               busy, busy_fp;
`ifdef SDRAM_ARB_STATS_EN
   logic [NP*16-1:0]   stat_cnt, stat_cnt_fp;
   logic [15:0]        stall_cnt, stall_cnt_fp;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_ack;
   int rr_order [4] = '{0, 1, 2, 0};

   always #5 clk_sys = ~clk_sys;

   sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(8), .RR_EN(1)) dut (
      .clk_sys(clk_sys), .RESET(RESET), .cep(cep), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ds(ds), .ack(ack), .rdata(rdata), .sdram_addr(sdram_addr),
      .sdram_din(sdram_din), .sdram_ds(sdram_ds), .sdram_we(sdram_we), .sdram_oe(sdram_oe),
      .sdram_out(sdram_out), .busy(busy)
`ifdef SDRAM_ARB_STATS_EN
      , .stat_cnt(stat_cnt), .stall_cnt(stall_cnt)
`endif
   );

   sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(8), .RR_EN(0)) dut_fp (
      .clk_sys(clk_sys), .RESET(RESET), .cep(cep), .req(req_fp), .we(we), .addr(addr),
      .wdata(wdata), .ds(ds), .ack(ack_fp), .rdata(rdata_fp), .sdram_addr(sdram_addr_fp),
      .sdram_din(sdram_din_fp), .sdram_ds(sdram_ds_fp), .sdram_we(sdram_we_fp),
      .sdram_oe(sdram_oe_fp), .sdram_out(sdram_out), .busy(busy_fp)
`ifdef SDRAM_ARB_STATS_EN
      , .stat_cnt(stat_cnt_fp), .stall_cnt(stall_cnt_fp)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   initial begin
      RESET = 1'b1; cep = 1'b0; req = '0; req_fp = '0; we = '0;
      addr = '0; wdata = '0; ds = '0; sdram_out = '0;
      addr[0*AW +: AW]    = 25'h00000A0;
      addr[1*AW +: AW]    = 25'h0000123;
      addr[2*AW +: AW]    = 25'h0000AB2;
      wdata[0*DW +: DW]   = 16'h55AA;
      wdata[1*DW +: DW]   = 16'h1111;
      wdata[2*DW +: DW]   = 16'h2222;
      ds[0*DSW +: DSW]    = 2'b01;
      ds[1*DSW +: DSW]    = 2'b11;
      ds[2*DSW +: DSW]    = 2'b10;

      // Reset values
      tick(2);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_addr", 64'(sdram_addr), 64'd0);
      chk("rst_we", 64'(sdram_we), 64'd0);
      chk("rst_oe", 64'(sdram_oe), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      RESET = 1'b0;
      tick(1);

      // Single read on port 1
      req = 3'b010; we = 3'b000; sdram_out = 16'hBEEF; cep = 1'b1;
      tick(1); cep = 1'b0;
      chk("rd_oe", 64'(sdram_oe), 64'd1);
      chk("rd_we", 64'(sdram_we), 64'd0);
      chk("rd_addr", 64'(sdram_addr), 64'h123);
      chk("rd_busy", 64'(busy), 64'd1);
      tick(7);
      chk("rd_ack_early", 64'(ack), 64'd0);
      tick(1);
      chk("rd_ack", 64'(ack), 64'b010);
      chk("rd_rdata", 64'(rdata), 64'hBEEF);
      req = 3'b000;
      tick(1);
      chk("rd_ack_once", 64'(ack), 64'd0);
      chk("rd_oe_off", 64'(sdram_oe), 64'd0);
      chk("rd_addr_hold", 64'(sdram_addr), 64'h123);
      chk("rd_idle", 64'(busy), 64'd0);

      // Write on port 0
      req = 3'b001; we = 3'b001; sdram_out = 16'h1234; cep = 1'b1;
      tick(1); cep = 1'b0;
      chk("wr_we", 64'(sdram_we), 64'd1);
      chk("wr_oe", 64'(sdram_oe), 64'd0);
      chk("wr_din", 64'(sdram_din), 64'h55AA);
      chk("wr_ds", 64'(sdram_ds), 64'b01);
      chk("wr_addr", 64'(sdram_addr), 64'hA0);
      tick(7);
      chk("wr_we_hold", 64'(sdram_we), 64'd1);
      chk("wr_din_hold", 64'(sdram_din), 64'h55AA);
      tick(1);
      chk("wr_ack", 64'(ack), 64'b001);
      chk("wr_rdata", 64'(rdata), 64'h1234);
      req = 3'b000; we = 3'b000;
      tick(1);
      chk("wr_we_off", 64'(sdram_we), 64'd0);
      chk("wr_ack_once", 64'(ack), 64'd0);

      // Round-robin contention from a fresh pointer
      RESET = 1'b1; tick(1); RESET = 1'b0; tick(1);
      req = 3'b111; sdram_out = 16'hBEEF;
      for (int g = 0; g < 4; g++) begin
         cep = 1'b1; tick(1); cep = 1'b0;
         chk("rr_addr", 64'(sdram_addr), 64'(addr[rr_order[g]*AW +: AW]));
         tick(7);
         chk("rr_ack_early", 64'(ack), 64'd0);
         tick(1);
         chk("rr_ack", 64'(ack), 64'(3'b001 << rr_order[g]));
         tick(1);
         chk("rr_ack_once", 64'(ack), 64'd0);
      end
      req = 3'b000;
`ifdef SDRAM_ARB_STATS_EN
      chk("stat_rr", 64'(stat_cnt), 64'({16'd1, 16'd1, 16'd2}));
      chk("stall_rr", 64'(stall_cnt), 64'd0);
`endif

      // Fixed priority: port 0 always wins over port 2
      req_fp = 3'b101;
      for (int s = 0; s < 3; s++) begin
         cep = 1'b1; tick(1); cep = 1'b0;
         chk("fp_addr", 64'(sdram_addr_fp), 64'hA0);
         tick(8);
         chk("fp_ack", 64'(ack_fp), 64'b001);
         tick(3);
      end
      req_fp = 3'b000;

      // cep every 4 cycles: ceps during an access are lost
      req = 3'b010;
      n_ack = 0;
      for (int t = 0; t < 24; t++) begin
         cep = ((t % 4) == 0);
         if (ack == 3'b010) n_ack++;
         if (t == 6) chk("c4_busy", 64'(busy), 64'd1);
         tick(1);
      end
      cep = 1'b0;
      chk("c4_acks", 64'(n_ack), 64'd2);
`ifdef SDRAM_ARB_STATS_EN
      chk("c4_stall", 64'(stall_cnt), 64'd4);
      chk("c4_stat", 64'(stat_cnt), 64'({16'd1, 16'd3, 16'd2}));
`endif
      req = 3'b000;

      // Reset during WAIT, then regrant the still-pending request
      req = 3'b100; cep = 1'b1;
      tick(1); cep = 1'b0;
      chk("mid_pre_oe", 64'(sdram_oe), 64'd1);
      tick(2);
      chk("mid_pre_busy", 64'(busy), 64'd1);
      RESET = 1'b1;
      #1;
      chk("mid_oe", 64'(sdram_oe), 64'd0);
      chk("mid_addr", 64'(sdram_addr), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_ack", 64'(ack), 64'd0);
      chk("mid_rdata", 64'(rdata), 64'd0);
      tick(1); RESET = 1'b0;
      n_ack = 0;
      for (int t = 0; t < 12; t++) begin
         if (ack != 3'b000) n_ack++;
         tick(1);
      end
      chk("mid_no_ack", 64'(n_ack), 64'd0);
`ifdef SDRAM_ARB_STATS_EN
      chk("mid_stall_clr", 64'(stall_cnt), 64'd0);
      chk("mid_stat_clr", 64'(stat_cnt), 64'd0);
`endif
      cep = 1'b1;
      tick(1); cep = 1'b0;
      chk("mid_regrant_addr", 64'(sdram_addr), 64'hAB2);
      chk("mid_regrant_oe", 64'(sdram_oe), 64'd1);
      tick(8);
      chk("mid_regrant_ack", 64'(ack), 64'b100);
      chk("mid_regrant_rdata", 64'(rdata), 64'hBEEF);
      req = 3'b000;
      tick(1);
      chk("mid_ack_once", 64'(ack), 64'd0);
`ifdef SDRAM_ARB_STATS_EN
      chk("mid_stat", 64'(stat_cnt), 64'({16'd1, 16'd0, 16'd0}));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
